// File: rtl/eject_sched_pkg.sv
// rtl/eject_sched_pkg.sv - ejection scheduler types and round-robin pick helper
`include "defines.v"

package eject_sched_pkg;

  localparam int STEER_W = `EJ_STEER_W;
  localparam int ADDR_N  = `EJ_ADDR_N;
  localparam int NCH     = 4;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } grant_t;

  // First eligible channel in the order rr, rr+1, rr+2, rr+3 (mod 4).
  function automatic grant_t rr_pick(input logic [NCH-1:0] elig, input logic [1:0] rr);
    grant_t     g;
    logic [1:0] k;
    g.hit = 1'b0;
    g.idx = rr;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = rr + 2'(i);
      if (elig[k]) begin
        g.hit = 1'b1;
        g.idx = k;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/defines.v
// rtl/defines.v - shared flit field and address width definitions
`ifndef EJECT_DEFINES_V
`define EJECT_DEFINES_V
`define EJ_STEER_W 16
`define EJ_VALID_F 15
`define EJ_DEST_F  14:12
`define EJ_ADDR_N  3
`endif

// File: rtl/ej_fifo.sv
// rtl/ej_fifo.sv - ejection FIFO with registered storage and occupancy count
module ej_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count < (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  // Storage is not cleared on reset, so mask stale entries while empty.
  assign dout = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/eject_sched.sv
// rtl/eject_sched.sv - round-robin ejection arbiter over four ring channels
module eject_sched
  import eject_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_N-1:0]  addr,
  input  logic [STEER_W-1:0] c0,
  input  logic [STEER_W-1:0] c1,
  input  logic [STEER_W-1:0] c2,
  input  logic [STEER_W-1:0] c3,
  output logic [STEER_W-1:0] c0_o,
  output logic [STEER_W-1:0] c1_o,
  output logic [STEER_W-1:0] c2_o,
  output logic [STEER_W-1:0] c3_o,
  output logic               ej_valid,
  output logic [STEER_W-1:0] ej_data,
  input  logic               ej_ready,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [STEER_W-1:0] ch [NCH];
  logic [STEER_W-1:0] ch_o [NCH];
  logic [NCH-1:0]     elig;
  logic [1:0]         rr;
  logic [CW-1:0]      count;
  logic               full;
  logic               grant;
  grant_t             pick;

  assign ch[0] = c0;
  assign ch[1] = c1;
  assign ch[2] = c2;
  assign ch[3] = c3;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      elig[k] = ch[k][`EJ_VALID_F] && (ch[k][`EJ_DEST_F] == addr);
    end
  end

  // Space is judged on the registered count only, keeping ej_ready off the c*_o path.
  assign full  = (count == CW'(DEPTH));
  assign pick  = rr_pick(elig, rr);
  assign grant = rst_n && pick.hit && !full;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_o[k] = (grant && (pick.idx == 2'(k))) ? '0 : ch[k];
    end
  end

  assign c0_o = ch_o[0];
  assign c1_o = ch_o[1];
  assign c2_o = ch_o[2];
  assign c3_o = ch_o[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant) rr <= pick.idx + 2'd1;
      if ((|elig) && full && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  ej_fifo #(.DEPTH(DEPTH), .W(STEER_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .din   (ch[pick.idx]),
    .pop   (ej_valid && ej_ready),
    .dout  (ej_data),
    .count (count)
  );

  assign ej_valid = (count != '0);

endmodule

// File: tb/tb_eject_sched.sv
// tb/tb_eject_sched.sv - directed table-driven bench for eject_sched
module tb_eject_sched;
  import eject_sched_pkg::*;

  typedef logic [STEER_W-1:0] flit_t;

  typedef struct {
    flit_t c [4];
    logic  rdy;
    flit_t o [4];
    logic  v;
    flit_t d;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ADDR_N-1:0]   addr = 3'd5;
  flit_t               c0 = '0, c1 = '0, c2 = '0, c3 = '0;
  flit_t               c0_o, c1_o, c2_o, c3_o;
  logic                ej_valid;
  flit_t               ej_data;
  logic                ej_ready = 1'b0;
  logic [7:0]          stall_cnt;

  int total = 0;
  int bad   = 0;

  vec_t tbl [10];

  eject_sched #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c0_o      (c0_o),
    .c1_o      (c1_o),
    .c2_o      (c2_o),
    .c3_o      (c3_o),
    .ej_valid  (ej_valid),
    .ej_data   (ej_data),
    .ej_ready  (ej_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic flit_t f(input int dest, input int pay);
    return {1'b1, 3'(dest), 12'(pay)};
  endfunction

  function automatic vec_t mkv(input flit_t a0, a1, a2, a3, input logic rdy,
                               input flit_t e0, e1, e2, e3, input logic v, input flit_t d);
    vec_t r;
    r.c[0] = a0; r.c[1] = a1; r.c[2] = a2; r.c[3] = a3;
    r.rdy = rdy;
    r.o[0] = e0; r.o[1] = e1; r.o[2] = e2; r.o[3] = e3;
    r.v = v;
    r.d = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input flit_t a0, a1, a2, a3);
    c0 = a0; c1 = a1; c2 = a2; c3 = a3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ej_ready = 1'b0;
    set_ch('0, '0, '0, '0);
    step();
    step();
    chk("rst_valid", 32'(ej_valid), 32'd0);
    chk("rst_data", 32'(ej_data), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = mkv(f(1,'h10), {1'b0,3'd5,12'h011}, f(5,'h222), '0, 1'b1,
                 f(1,'h10), {1'b0,3'd5,12'h011}, '0, '0, 1'b1, f(5,'h222));
    tbl[1] = mkv(f(5,'h300), f(5,'h301), f(5,'h302), f(5,'h303), 1'b1,
                 f(5,'h300), f(5,'h301), f(5,'h302), '0, 1'b1, f(5,'h303));
    tbl[2] = mkv(f(5,'h400), f(5,'h401), f(5,'h402), f(5,'h403), 1'b1,
                 '0, f(5,'h401), f(5,'h402), f(5,'h403), 1'b1, f(5,'h400));
    tbl[3] = mkv(f(5,'h500), f(5,'h501), f(5,'h502), f(5,'h503), 1'b1,
                 f(5,'h500), '0, f(5,'h502), f(5,'h503), 1'b1, f(5,'h501));
    tbl[4] = mkv(f(5,'h600), f(5,'h601), f(5,'h602), f(5,'h603), 1'b1,
                 f(5,'h600), f(5,'h601), '0, f(5,'h603), 1'b1, f(5,'h602));
    tbl[5] = mkv('0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 1'b0, '0);
    tbl[6] = mkv(f(5,'h700), f(5,'h701), f(2,'h702), '0, 1'b1,
                 '0, f(5,'h701), f(2,'h702), '0, 1'b1, f(5,'h700));
    tbl[7] = mkv(f(5,'h800), '0, '0, f(5,'h803), 1'b0,
                 f(5,'h800), '0, '0, '0, 1'b1, f(5,'h700));
    tbl[8] = mkv('0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 1'b1, f(5,'h803));
    tbl[9] = mkv('0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 1'b0, '0);

    // Table: latency, rotation of rr, pass-through, simultaneous push/pop.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_ch(tbl[i].c[0], tbl[i].c[1], tbl[i].c[2], tbl[i].c[3]);
      ej_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_c0_o", i), 32'(c0_o), 32'(tbl[i].o[0]));
      chk($sformatf("v%0d_c1_o", i), 32'(c1_o), 32'(tbl[i].o[1]));
      chk($sformatf("v%0d_c2_o", i), 32'(c2_o), 32'(tbl[i].o[2]));
      chk($sformatf("v%0d_c3_o", i), 32'(c3_o), 32'(tbl[i].o[3]));
      step();
      chk($sformatf("v%0d_valid", i), 32'(ej_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_data", i), 32'(ej_data), 32'(tbl[i].d));
    end

    // All four eligible from rr=0: grants walk 0,1,2,3.
    do_reset();
    ej_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ch(f(5,'hA00), f(5,'hA01), f(5,'hA02), f(5,'hA03));
      #1;
      chk($sformatf("rr%0d_c0_o", i), 32'(c0_o), (i == 0) ? 32'd0 : 32'(f(5,'hA00)));
      chk($sformatf("rr%0d_c1_o", i), 32'(c1_o), (i == 1) ? 32'd0 : 32'(f(5,'hA01)));
      chk($sformatf("rr%0d_c2_o", i), 32'(c2_o), (i == 2) ? 32'd0 : 32'(f(5,'hA02)));
      chk($sformatf("rr%0d_c3_o", i), 32'(c3_o), (i == 3) ? 32'd0 : 32'(f(5,'hA03)));
      step();
      chk($sformatf("rr%0d_data", i), 32'(ej_data), 32'(f(5, 'hA00 + i)));
    end

    // Fill with ej_ready low, then stall and saturate.
    do_reset();
    ej_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(f(5, i), '0, '0, '0);
      #1;
      chk($sformatf("fill%0d_c0_o", i), 32'(c0_o), 32'd0);
      step();
    end
    chk("full_stall0", 32'(stall_cnt), 32'd0);
    for (int n = 0; n < 300; n++) begin
      set_ch(f(5, 'h100 + n), '0, '0, '0);
      #1;
      if (n < 2) chk($sformatf("deflect%0d", n), 32'(c0_o), 32'(f(5, 'h100 + n)));
      step();
      if (n < 3) chk($sformatf("stall_inc%0d", n), 32'(stall_cnt), 32'(n + 1));
    end
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    chk("full_valid", 32'(ej_valid), 32'd1);
    chk("full_head_held", 32'(ej_data), 32'(f(5, 0)));

    // Full with a pop: no grant this cycle, grant on the next.
    set_ch('0, f(5,'hA1), '0, '0);
    ej_ready = 1'b1;
    #1;
    chk("full_pop_nogrant", 32'(c1_o), 32'(f(5,'hA1)));
    step();
    chk("full_pop_head", 32'(ej_data), 32'(f(5, 1)));
    ej_ready = 1'b0;
    #1;
    chk("next_grant", 32'(c1_o), 32'd0);
    step();
    set_ch('0, '0, '0, '0);
    ej_ready = 1'b1;
    step();
    chk("drain1", 32'(ej_data), 32'(f(5, 2)));
    step();
    chk("drain2", 32'(ej_data), 32'(f(5, 3)));
    step();
    chk("drain3", 32'(ej_data), 32'(f(5, 'hA1)));
    step();
    chk("drain_empty", 32'(ej_valid), 32'd0);

    // Asynchronous reset mid-burst discards buffered flits.
    do_reset();
    ej_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(f(5, 'hC0 + i), '0, '0, '0);
      step();
    end
    chk("pre_rst_valid", 32'(ej_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ej_valid), 32'd0);
    chk("async_data", 32'(ej_data), 32'd0);
    chk("rst_passthru", 32'(c0_o), 32'(f(5, 'hC2)));
    step();
    step();
    rst_n = 1'b1;
    set_ch('0, '0, f(5, 'hCC), '0);
    ej_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(c2_o), 32'd0);
    step();
    chk("post_rst_valid", 32'(ej_valid), 32'd1);
    chk("post_rst_data", 32'(ej_data), 32'(f(5, 'hCC)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
